// File: rtl/count_display_ctrl_if.sv
// Count input from the up/down counter and 2-digit 7-segment display outputs.
// master drives count and observes the display; slave is the display controller.
interface count_display_ctrl_if;
    logic [3:0] count;
    logic [6:0] seg;
    logic [1:0] an;
    logic       at_max;
    logic       at_min;
    logic       blink;

    modport master (
        output count,
        input  seg,
        input  an,
        input  at_max,
        input  at_min,
        input  blink
    );

    modport slave (
        input  count,
        output seg,
        output an,
        output at_max,
        output at_min,
        output blink
    );
endinterface

// File: rtl/count_display_ctrl.sv
// Splits a 0..15 count into two decimal digits and multiplexes them onto a 2-digit 7-seg display.
// Latency count->seg is 2 edges; no backpressure, the display blinks while the count rests at 0 or 15.
module count_display_ctrl #(
    parameter int unsigned REFRESH_DIV = 4,
    parameter int unsigned HOLD_CYC    = 4,
    parameter int unsigned BLINK_DIV   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    count_display_ctrl_if.slave  disp
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        SHOW,
        LIMIT_WAIT,
        BLINK
    } state_t;

    state_t          state;
    logic [3:0]      count_q;
    logic [3:0]      lim_q;
    logic [RW-1:0]   ref_cnt;
    logic            digit_sel;
    logic [HW-1:0]   hold_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            phase_on;

    logic            tens;
    logic [3:0]      ones;
    logic            is_limit;
    logic            resting;
    logic            blinking;
    logic            blank;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign tens     = (count_q >= 4'd10);
    assign ones     = tens ? (count_q - 4'd10) : count_q;
    assign is_limit = (count_q == 4'd0) || (count_q == 4'd15);
    assign resting  = (count_q == lim_q);
    // Blanking only applies while still parked on the limit, so leaving it never shows a dark frame.
    assign blinking = (state == BLINK) && resting;
    assign blank    = blinking && !phase_on;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= 4'd0;
            lim_q       <= 4'd0;
            ref_cnt     <= '0;
            digit_sel   <= 1'b0;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            phase_on    <= 1'b1;
            state       <= SHOW;
            disp.seg    <= 7'h00;
            disp.an     <= 2'b01;
            disp.at_max <= 1'b0;
            disp.at_min <= 1'b0;
            disp.blink  <= 1'b0;
        end else begin
            count_q <= disp.count;

            if (ref_cnt == REF_LAST) begin
                ref_cnt   <= '0;
                digit_sel <= ~digit_sel;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            if (blank) begin
                disp.seg <= 7'h00;
            end else if (digit_sel) begin
                disp.seg <= tens ? 7'h06 : 7'h00;
            end else begin
                disp.seg <= seg_code(ones);
            end
            disp.an     <= digit_sel ? 2'b10 : 2'b01;
            disp.at_max <= (count_q == 4'd15);
            disp.at_min <= (count_q == 4'd0);
            disp.blink  <= blinking;

            case (state)
                SHOW: begin
                    if (is_limit) begin
                        state    <= LIMIT_WAIT;
                        hold_cnt <= HW'(1);
                        lim_q    <= count_q;
                    end
                end
                LIMIT_WAIT: begin
                    if (resting) begin
                        if (hold_cnt >= HOLD_LAST) begin
                            state     <= BLINK;
                            hold_cnt  <= HOLD_MAX;
                            phase_on  <= 1'b1;
                            blink_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (is_limit) begin
                        hold_cnt <= HW'(1);
                        lim_q    <= count_q;
                    end else begin
                        state    <= SHOW;
                        hold_cnt <= '0;
                    end
                end
                BLINK: begin
                    if (resting) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            phase_on  <= ~phase_on;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end else if (is_limit) begin
                        state     <= LIMIT_WAIT;
                        hold_cnt  <= HW'(1);
                        lim_q     <= count_q;
                        phase_on  <= 1'b1;
                        blink_cnt <= '0;
                    end else begin
                        state     <= SHOW;
                        hold_cnt  <= '0;
                        phase_on  <= 1'b1;
                        blink_cnt <= '0;
                    end
                end
                default: state <= SHOW;
            endcase
        end
    end
endmodule

// File: tb/tb_count_display_ctrl.sv
// Directed bench for count_display_ctrl: expected display words are queued as each count is
// driven and checked against the outputs sampled just after the edge that produces them.
module tb_count_display_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    count_display_ctrl_if disp_if ();

    count_display_ctrl #(
        .REFRESH_DIV(4),
        .HOLD_CYC   (4),
        .BLINK_DIV  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .disp (disp_if.slave)
    );

    typedef struct {
        int         edge_n;
        logic [6:0] seg;
        logic [1:0] an;
        logic       at_max;
        logic       at_min;
        logic       blink;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         edge_k;
    logic [3:0] mq;
    int         run;

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Output at edge k reflects the value latched at edge k-1 and how long it has been held (r).
    // Blink begins once a limit value has been held for 5 latched edges; phases last 8 edges.
    function automatic exp_t make_exp(input int k, input logic [3:0] q, input int r);
        exp_t e;
        logic lim, blk, off, tens;
        int   ones;
        lim  = (q == 4'd0) || (q == 4'd15);
        blk  = lim && (r >= 5);
        off  = blk && ((((r - 5) / 8) % 2) == 1);
        tens = (q >= 4'd10);
        ones = tens ? int'(q) - 10 : int'(q);
        e.edge_n = k;
        e.an     = ((((k - 1) / 4) % 2) == 1) ? 2'b10 : 2'b01;
        if (off)                 e.seg = 7'h00;
        else if (e.an == 2'b01)  e.seg = digit_seg(ones);
        else                     e.seg = tens ? 7'h06 : 7'h00;
        e.at_max = (q == 4'd15);
        e.at_min = (q == 4'd0);
        e.blink  = blk;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s edge %0d: observed %h expected %h", tag, edge_k, obs, expv);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_seg"},    disp_if.seg,    7'h00);
        chk({tag, "_an"},     7'(disp_if.an), 7'h01);
        chk({tag, "_at_max"}, 7'(disp_if.at_max), 7'h00);
        chk({tag, "_at_min"}, 7'(disp_if.at_min), 7'h00);
        chk({tag, "_blink"},  7'(disp_if.blink),  7'h00);
    endtask

    task automatic model_reset();
        edge_k = 0;
        mq     = 4'd0;
        run    = 1;
        sb.delete();
    endtask

    task automatic step(input logic [3:0] c);
        exp_t e;
        @(negedge clk);
        sb.push_back(make_exp(edge_k + 1, mq, run));
        disp_if.count = c;
        @(posedge clk);
        edge_k++;
        if (c == mq) run++;
        else begin
            mq  = c;
            run = 1;
        end
        #1;
        while (sb.size() > 0 && sb[0].edge_n == edge_k) begin
            e = sb.pop_front();
            chk("seg",    disp_if.seg,          e.seg);
            chk("an",     7'(disp_if.an),       7'(e.an));
            chk("at_max", 7'(disp_if.at_max),   7'(e.at_max));
            chk("at_min", 7'(disp_if.at_min),   7'(e.at_min));
            chk("blink",  7'(disp_if.blink),    7'(e.blink));
        end
    endtask

    task automatic hold(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) step(c);
    endtask

    initial begin
        disp_if.count = 4'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_reset_vals("por");
        @(posedge clk);
        @(posedge clk);
        #1 check_reset_vals("por_hold");
        #1 reset = 1'b1;
        model_reset();

        hold(4'd7, 12);
        hold(4'd12, 12);
        hold(4'd15, 20);
        hold(4'd14, 12);
        hold(4'd15, 30);

        // Reset between edges while blinking
        #2 reset = 1'b0;
        #1 check_reset_vals("mid");
        @(posedge clk);
        @(posedge clk);
        #1 check_reset_vals("mid_hold");
        #1 reset = 1'b1;
        model_reset();

        hold(4'd9, 8);
        hold(4'd0, 3);
        hold(4'd15, 12);
        hold(4'd3, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
